uart_rx_frontend: RTL and testbench
===================================

Name: uart_rx_frontend

Overview:
- On-chip UART receiver. Deserialises 8N1 frames from the host serial line, `serial_in`, into bytes.
- Presents each received byte to the CPU's memory-mapped UART logic over a ready/valid handshake.
- Detects framing errors and overruns.
- Counterpart of the on-chip transmitter. Sits between the top-level pin and the UART MMIO registers.

Parameters:
- CLOCK_FREQ, 50_000_000, core clock frequency in Hz.
- BAUD_RATE, 115_200, line rate in bits/s.
- CLOCKS_PER_BIT, CLOCK_FREQ/BAUD_RATE, derived localparam. Must be >= 4; elaboration fails otherwise.
- SAMPLE_POINT, CLOCKS_PER_BIT/2, derived localparam. Counter value at which a bit is sampled.

Ports:
- clk  input  1  core clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- serial_in  input  1  asynchronous serial line; idle high.
- data_out  output  8  received byte; stable while data_out_valid is high.
- data_out_valid  output  1  byte available.
- data_out_ready  input  1  consumer accepts the byte when valid && ready at a rising edge.
- framing_error  output  1  one-cycle pulse; stop bit sampled low.
- overrun  output  1  one-cycle pulse; a good frame completed while the holding register was still full.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rst_n low):
  - FSM to IDLE; counters to 0.
  - data_out=0x00, data_out_valid=0, framing_error=0, overrun=0, busy=0.
  - Both synchroniser flops preset to 1.
- Reset mid-frame aborts the frame silently; no error pulse is generated.
- Input path: 2-flop synchroniser on serial_in produces rx_s. All decisions use rx_s only.
- Bit counter: clk_cnt counts 0..CLOCKS_PER_BIT-1 and is cleared on every state transition. Bit index counts 0..7; data is LSB first.
- FSM states:
  - IDLE: when rx_s==0, go to START and clear clk_cnt.
  - START: when clk_cnt==SAMPLE_POINT:
    - if rx_s==0, go to DATA with bit index 0 and clk_cnt cleared;
    - else false start, return to IDLE with no pulse.
  - DATA: when clk_cnt==CLOCKS_PER_BIT-1:
    - shift rx_s into shift_reg[7] (right shift) and clear clk_cnt;
    - after bit index 7 is sampled, go to STOP.
  - STOP: when clk_cnt==CLOCKS_PER_BIT-1, sample rx_s, then go to IDLE in the same cycle (frame ends mid-stop-bit so back-to-back frames are not missed):
    - rx_s==1 and holding register empty (valid==0, or valid&&ready this cycle): load data_out from shift_reg; data_out_valid=1 next cycle.
    - rx_s==1 and holding register full without ready: discard the new byte; pulse overrun; data_out unchanged.
    - rx_s==0: discard the byte; pulse framing_error. If the line stays low, IDLE sees rx_s==0 and restarts the start-bit check.
- Handshake:
  - data_out_valid clears on the edge where valid&&ready, unless a new load occurs in the same cycle; in that case valid stays 1 and data_out takes the new byte.
  - data_out must not change while valid && !ready.
- Latency: from the serial_in falling edge to data_out_valid high is 2 + SAMPLE_POINT + 9*CLOCKS_PER_BIT + 2 cycles, ±1 cycle for synchroniser phase.
- Sampling tolerance: sampling is at mid-bit.
  - Correct reception is required for up to ±2% baud mismatch when CLOCKS_PER_BIT >= 16.
  - Exact-rate reception is required for CLOCKS_PER_BIT >= 4.
- Counter widths: $clog2(CLOCKS_PER_BIT) bits for clk_cnt; 3 bits for bit index. No wrap other than explicit clears.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE, START, DATA, STOP);
  - localparams DATA_BITS=8 and MIN_CLOCKS_PER_BIT=4.
  - Reused by the transmitter.
- One natural sub-module: sync_2ff. A generic two-flop synchroniser with reset value parameter RESET_VAL=1. It is also usable for other async inputs.

Test Plan:
- CLOCK_FREQ=50e6, BAUD_RATE=10e6 (CLOCKS_PER_BIT=5), ready held high; send 0x78, 0x79, 0x7a, 0x0d back-to-back → four valid pulses with data_out 0x78, 0x79, 0x7a, 0x0d in order; no error or overrun pulses.
- Ready held low; send 0x31 then 0x35 → data_out stays 0x31 with valid high; one overrun pulse at the second frame's stop sample. Raise ready → valid drops next cycle.
- Frame 0x55 with stop bit driven 0 → framing_error pulses once; valid never asserts. A following good 0xA5 frame is received correctly.
- Low glitch on serial_in of 1 clock (< SAMPLE_POINT) in IDLE → returns to IDLE; no valid, no error; busy high for at most SAMPLE_POINT+3 cycles.
- rst_n asserted mid-DATA of 0xFF, released, then 0x3e sent → outputs reset immediately; only 0x3e is delivered.
- BAUD_RATE=115200 (CLOCKS_PER_BIT=434), host bit period 2% long, send 0x00 and 0xFF → both received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and frame constants.
package uart_pkg;

  localparam int DATA_BITS          = 8;
  localparam int MIN_CLOCKS_PER_BIT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs; flops reset to RESET_VAL.
module sync_2ff #(
  parameter int       WIDTH     = 1,
  parameter bit       RESET_VAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // the pre-edge values; blocking here would collapse the chain into one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= {WIDTH{RESET_VAL}};
      sync_q <= {WIDTH{RESET_VAL}};
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule : sync_2ff

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a one-entry holding register
// with a ready/valid handshake, plus framing-error and overrun pulses.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_out_valid,
  input  logic                 data_out_ready,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CLOCKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_POINT   = CLOCKS_PER_BIT / 2;
  localparam int CNT_W          = $clog2(CLOCKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_POINT);
  localparam logic [2:0]       BIT_LAST   = 3'(DATA_BITS - 1);

  generate
    if (CLOCKS_PER_BIT < MIN_CLOCKS_PER_BIT) begin : g_cpb_check
      $error("uart_rx_frontend: CLOCKS_PER_BIT (%0d) below minimum %0d",
             CLOCKS_PER_BIT, MIN_CLOCKS_PER_BIT);
    end
  endgenerate

  logic rx_s;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (serial_in),
    .sync_o  (rx_s)
  );

  uart_state_e          state_q,   state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;

  logic [DATA_BITS-1:0] data_q,    data_d;
  logic                 valid_q,   valid_d;
  logic                 ferr_q,    ferr_d;
  logic                 ovr_q,     ovr_d;

  logic stop_sample;
  logic accept;
  logic load;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d   = START;
          clk_cnt_d = '0;
        end
      end

      START: begin
        if (clk_cnt_q == CNT_SAMPLE) begin
          clk_cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d   = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == BIT_LAST) begin
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      STOP: begin
        // Leave mid-stop-bit so a start bit immediately following is not missed.
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        clk_cnt_d = '0;
      end
    endcase
  end

  // Output logic: holding register, handshake and status pulses
  always_comb begin
    stop_sample = (state_q == STOP) && (clk_cnt_q == CNT_LAST);
    accept      = valid_q && data_out_ready;
    load        = stop_sample && rx_s && (!valid_q || accept);

    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end

    ferr_d = stop_sample && !rx_s;
    ovr_d  = stop_sample && rx_s && valid_q && !data_out_ready;
  end

  // NOTE: the holding register is reset along with control because its
  // value is architecturally visible (data_out reads 0x00 after reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign framing_error  = ferr_q;
  assign overrun        = ovr_q;
  assign busy           = (state_q != IDLE);

endmodule : uart_rx_frontend

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend: a fast instance (5 clocks/bit) and a
// 115200-baud instance driven 2% slow, each checked against a byte scoreboard.
module tb_uart_rx_frontend;

  localparam int CPB_F  = 5;
  localparam int SP_F   = CPB_F / 2;
  localparam int LAT_F  = 2 + SP_F + 9 * CPB_F + 2;
  localparam int BIT_S  = 443;  // 434 clocks/bit nominal, host 2% long

  logic       clk = 1'b0;
  logic       rst_n;
  logic       serial_fast, serial_slow;
  logic       ready_fast, ready_slow;
  logic [7:0] f_data, s_data;
  logic       f_valid, s_valid;
  logic       f_ferr, s_ferr;
  logic       f_ovr, s_ovr;
  logic       f_busy, s_busy;

  always #5 clk = ~clk;

  uart_rx_frontend #(
    .CLOCK_FREQ (50_000_000),
    .BAUD_RATE  (10_000_000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .serial_in      (serial_fast),
    .data_out       (f_data),
    .data_out_valid (f_valid),
    .data_out_ready (ready_fast),
    .framing_error  (f_ferr),
    .overrun        (f_ovr),
    .busy           (f_busy)
  );

  uart_rx_frontend #(
    .CLOCK_FREQ (50_000_000),
    .BAUD_RATE  (115_200)
  ) dut_slow (
    .clk            (clk),
    .rst_n          (rst_n),
    .serial_in      (serial_slow),
    .data_out       (s_data),
    .data_out_valid (s_valid),
    .data_out_ready (ready_slow),
    .framing_error  (s_ferr),
    .overrun        (s_ovr),
    .busy           (s_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] q_fast[$];
  logic [7:0] q_slow[$];

  int   f_ferr_cnt = 0, f_ovr_cnt = 0;
  int   s_ferr_cnt = 0, s_ovr_cnt = 0;
  logic f_valid_prev = 1'b0;
  logic lat_armed    = 1'b0;
  int   lat_start    = 0;
  int   lat_rise     = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_fast(input logic [7:0] b, input logic stop_bit);
    serial_fast = 1'b0;
    idle(CPB_F);
    for (int i = 0; i < 8; i++) begin
      serial_fast = b[i];
      idle(CPB_F);
    end
    serial_fast = stop_bit;
    idle(CPB_F);
    serial_fast = 1'b1;
  endtask

  task automatic send_slow(input logic [7:0] b);
    serial_slow = 1'b0;
    idle(BIT_S);
    for (int i = 0; i < 8; i++) begin
      serial_slow = b[i];
      idle(BIT_S);
    end
    serial_slow = 1'b1;
    idle(BIT_S);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: pop an expected byte at every accepted handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (f_ferr) f_ferr_cnt++;
      if (f_ovr)  f_ovr_cnt++;
      if (f_valid && !f_valid_prev && lat_armed) begin
        lat_rise  = cyc;
        lat_armed = 1'b0;
      end
      if (f_valid && ready_fast) begin
        logic [7:0] exp;
        exp = (q_fast.size() > 0) ? q_fast.pop_front() : 8'hxx;
        check("fast_byte", {24'h0, f_data}, {24'h0, exp});
      end
      f_valid_prev = f_valid;

      if (s_ferr) s_ferr_cnt++;
      if (s_ovr)  s_ovr_cnt++;
      if (s_valid && ready_slow) begin
        logic [7:0] exp_s;
        exp_s = (q_slow.size() > 0) ? q_slow.pop_front() : 8'hxx;
        check("slow_byte", {24'h0, s_data}, {24'h0, exp_s});
      end
    end
  end

  initial begin
    int lat, lat_exp, busy_cnt, busy_exp, valid_cnt, ferr_before;

    rst_n       = 1'b0;
    serial_fast = 1'b1;
    serial_slow = 1'b1;
    ready_fast  = 1'b1;
    ready_slow  = 1'b1;
    idle(3);

    check("rst_data",  {24'h0, f_data}, 32'h0);
    check("rst_valid", {31'h0, f_valid}, 32'h0);
    check("rst_ferr",  {31'h0, f_ferr}, 32'h0);
    check("rst_ovr",   {31'h0, f_ovr}, 32'h0);
    check("rst_busy",  {31'h0, f_busy}, 32'h0);
    check("rst_slow_valid", {31'h0, s_valid}, 32'h0);
    check("rst_slow_busy",  {31'h0, s_busy}, 32'h0);

    rst_n = 1'b1;
    idle(3);

    // Back-to-back frames with ready held high
    lat_start = cyc;
    lat_armed = 1'b1;
    q_fast.push_back(8'h78); send_fast(8'h78, 1'b1);
    q_fast.push_back(8'h79); send_fast(8'h79, 1'b1);
    q_fast.push_back(8'h7a); send_fast(8'h7a, 1'b1);
    q_fast.push_back(8'h0d); send_fast(8'h0d, 1'b1);
    idle(20);
    check("b2b_queue_drained", q_fast.size(), 32'd0);
    check("b2b_no_ferr", f_ferr_cnt, 32'd0);
    check("b2b_no_ovr",  f_ovr_cnt, 32'd0);
    lat      = lat_rise - lat_start;
    lat_exp  = (lat < LAT_F - 1) ? LAT_F - 1 : (lat > LAT_F + 1) ? LAT_F + 1 : lat;
    check("latency", lat, lat_exp);

    // Overrun with ready held low
    ready_fast = 1'b0;
    q_fast.push_back(8'h31);
    send_fast(8'h31, 1'b1);
    send_fast(8'h35, 1'b1);
    idle(10);
    check("ovr_data_held", {24'h0, f_data}, 32'h31);
    check("ovr_valid_held", {31'h0, f_valid}, 32'h1);
    check("ovr_count", f_ovr_cnt, 32'd1);
    check("ovr_no_ferr", f_ferr_cnt, 32'd0);
    ready_fast = 1'b1;
    tick();
    tick();
    check("ovr_valid_drop", {31'h0, f_valid}, 32'h0);
    check("ovr_queue_drained", q_fast.size(), 32'd0);

    // Framing error, then recovery
    send_fast(8'h55, 1'b0);
    idle(30);
    check("ferr_count", f_ferr_cnt, 32'd1);
    check("ferr_no_valid", {31'h0, f_valid}, 32'h0);
    q_fast.push_back(8'ha5);
    send_fast(8'ha5, 1'b1);
    idle(20);
    check("ferr_recover_drained", q_fast.size(), 32'd0);
    check("ferr_count_stable", f_ferr_cnt, 32'd1);

    // One-clock glitch in IDLE
    ferr_before = f_ferr_cnt;
    busy_cnt    = 0;
    valid_cnt   = 0;
    serial_fast = 1'b0;
    tick();
    serial_fast = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (f_busy)  busy_cnt++;
      if (f_valid) valid_cnt++;
    end
    busy_exp = (busy_cnt > SP_F + 3) ? SP_F + 3 : (busy_cnt < 1) ? 1 : busy_cnt;
    check("glitch_busy_cycles", busy_cnt, busy_exp);
    check("glitch_no_valid", valid_cnt, 32'd0);
    check("glitch_no_ferr", f_ferr_cnt, ferr_before);
    check("glitch_back_idle", {31'h0, f_busy}, 32'h0);

    // Reset in the middle of a 0xFF frame
    serial_fast = 1'b0;
    idle(CPB_F);
    serial_fast = 1'b1;
    idle(2 * CPB_F);
    check("midframe_busy", {31'h0, f_busy}, 32'h1);
    ferr_before = f_ferr_cnt;
    rst_n = 1'b0;
    #2;
    check("midrst_data",  {24'h0, f_data}, 32'h0);
    check("midrst_valid", {31'h0, f_valid}, 32'h0);
    check("midrst_busy",  {31'h0, f_busy}, 32'h0);
    check("midrst_ferr",  {31'h0, f_ferr}, 32'h0);
    idle(3);
    rst_n = 1'b1;
    idle(8 * CPB_F);
    q_fast.push_back(8'h3e);
    send_fast(8'h3e, 1'b1);
    idle(20);
    check("midrst_after_drained", q_fast.size(), 32'd0);
    check("midrst_no_ferr", f_ferr_cnt, ferr_before);

    // 115200 baud with host bit period 2% long
    q_slow.push_back(8'h00);
    send_slow(8'h00);
    q_slow.push_back(8'hff);
    send_slow(8'hff);
    idle(300);
    check("slow_queue_drained", q_slow.size(), 32'd0);
    check("slow_no_ferr", s_ferr_cnt, 32'd0);
    check("slow_no_ovr",  s_ovr_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_rx_frontend
